// File: rtl/fir_coef_loader_if.sv
// Coefficient stream between an upstream coefficient source and the FIR coefficient loader.
// The master drives the load request and the coefficient words; the slave returns coef_ready.
interface fir_coef_loader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  load_start;
  logic                  coef_valid;
  logic [DATA_WIDTH-1:0] coef_data;
  logic                  coef_last;
  logic                  coef_ready;

  modport master (
    output load_start,
    output coef_valid,
    output coef_data,
    output coef_last,
    input  coef_ready
  );

  modport slave (
    input  load_start,
    input  coef_valid,
    input  coef_data,
    input  coef_last,
    output coef_ready
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader: words are collected into a shadow bank and copied
// atomically into the active bank (h_out) only after a complete, correctly terminated set.
module fir_coef_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_WIDTH_F = 14,
  parameter int NUM_TAPS     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  fir_coef_loader_if.slave               coef_if,
  input  logic                           enable_in,
  output logic                           fir_enable,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] h_out,
  output logic                           bank_valid,
  output logic                           busy,
  output logic                           commit_pulse,
  output logic                           load_err
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  // Coefficient format is Q(DATA_WIDTH-DATA_WIDTH_F).DATA_WIDTH_F; words pass through untouched.
  if (NUM_TAPS < 2 || DATA_WIDTH_F > DATA_WIDTH) begin : g_param_check
    $error("fir_coef_loader: NUM_TAPS must be >= 2 and DATA_WIDTH_F <= DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_index;
  logic [DATA_WIDTH-1:0]            r_shadow [NUM_TAPS];
  logic [NUM_TAPS*DATA_WIDTH-1:0]   r_active;
  logic                             r_bank_valid;
  logic                             r_coef_ready;
  logic                             r_busy;
  logic                             r_commit_pulse;
  logic                             r_load_err;

  logic w_xfer;
  logic w_at_end;

  // coef_ready is registered and high exactly while in LOAD, so it qualifies the transfer.
  assign w_xfer   = coef_if.coef_valid & r_coef_ready;
  assign w_at_end = (r_index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_index        <= '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        r_shadow[k] <= '0;
      end
      r_active       <= '0;
      r_bank_valid   <= 1'b0;
      r_coef_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_commit_pulse <= 1'b0;
      r_load_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (coef_if.load_start) begin
            r_state      <= LOAD;
            r_index      <= '0;
            r_coef_ready <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_shadow[r_index] <= coef_if.coef_data;
            r_index           <= r_index + 1'b1;
            if (coef_if.coef_last && w_at_end) begin
              r_state      <= COMMIT;
              r_coef_ready <= 1'b0;
            end else if (coef_if.coef_last || w_at_end) begin
              // Short or long set: discard it, active bank stays as it was.
              r_state      <= IDLE;
              r_coef_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_load_err   <= 1'b1;
            end
          end
        end
        COMMIT: begin
          for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            r_active[k*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[k];
          end
          r_bank_valid   <= 1'b1;
          r_commit_pulse <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_coef_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign coef_if.coef_ready = r_coef_ready;
  assign h_out              = r_active;
  assign bank_valid         = r_bank_valid;
  assign busy               = r_busy;
  assign commit_pulse       = r_commit_pulse;
  assign load_err           = r_load_err;
  assign fir_enable         = enable_in & r_bank_valid;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: directed scenarios plus randomized coefficient sets
// compared against a transaction-level model of the active bank.
module tb_fir_coef_loader;
  localparam int DW = 16;
  localparam int NT = 8;
  localparam int HW = NT * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_in;
  logic          fir_enable;
  logic [HW-1:0] h_out;
  logic          bank_valid;
  logic          busy;
  logic          commit_pulse;
  logic          load_err;

  fir_coef_loader_if #(.DATA_WIDTH(DW)) lif ();

  fir_coef_loader #(
    .DATA_WIDTH  (DW),
    .DATA_WIDTH_F(14),
    .NUM_TAPS    (NT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coef_if     (lif),
    .enable_in   (enable_in),
    .fir_enable  (fir_enable),
    .h_out       (h_out),
    .bank_valid  (bank_valid),
    .busy        (busy),
    .commit_pulse(commit_pulse),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: the committed coefficient set and whether one exists.
  logic [DW-1:0] m_active [NT];
  bit            m_valid;
  logic [DW-1:0] stim [NT];
  bit            en_force;

  task automatic check_eq(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] exp_h();
    logic [HW-1:0] h;
    for (int k = 0; k < NT; k++) h[k*DW +: DW] = m_active[k];
    return h;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) m_active[k] = '0;
    m_valid = 1'b0;
  endtask

  task automatic step();
    enable_in = en_force ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_common(input string tag);
    check_eq({tag, "_h_out"}, h_out, exp_h());
    check_eq({tag, "_bank_valid"}, HW'(bank_valid), HW'(m_valid));
    check_eq({tag, "_fir_enable"}, HW'(fir_enable), HW'(enable_in & m_valid));
  endtask

  task automatic idle_inputs();
    lif.load_start = 1'b0;
    lif.coef_valid = 1'b0;
    lif.coef_last  = 1'b0;
    lif.coef_data  = '0;
  endtask

  // Sends stim[0..n-1]; last flag only on word n-1 when last_final. Optional random gaps and
  // a spurious load_start alongside word 2.
  task automatic send_set(input int n, input bit last_final, input bit gaps, input bit restart);
    bit ok;
    lif.load_start = 1'b1;
    step();
    lif.load_start = 1'b0;
    check_eq("ready_in_load", HW'(lif.coef_ready), HW'(1));
    check_eq("busy_in_load", HW'(busy), HW'(1));
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          lif.coef_valid = 1'b0;
          lif.load_start = restart;
          step();
          lif.load_start = 1'b0;
          check_eq("gap_busy", HW'(busy), HW'(1));
          check_eq("gap_ready", HW'(lif.coef_ready), HW'(1));
        end
      end
      lif.coef_valid = 1'b1;
      lif.coef_data  = stim[i];
      lif.coef_last  = (i == n - 1) ? last_final : 1'b0;
      lif.load_start = restart && (i == 2);
      step();
      idle_inputs();
      if (i < n - 1) check_eq("mid_commit", HW'(commit_pulse), HW'(0));
    end
    ok = (n == NT) && last_final;
    if (ok) begin
      check_eq("commit_busy", HW'(busy), HW'(1));
      check_eq("commit_ready", HW'(lif.coef_ready), HW'(0));
      check_eq("pre_commit_pulse", HW'(commit_pulse), HW'(0));
      check_common("pre_commit");
      step();
      for (int k = 0; k < NT; k++) m_active[k] = stim[k];
      m_valid = 1'b1;
      check_eq("commit_pulse", HW'(commit_pulse), HW'(1));
      check_eq("commit_err", HW'(load_err), HW'(0));
      check_eq("post_commit_busy", HW'(busy), HW'(0));
      check_common("post_commit");
      step();
      check_eq("commit_pulse_end", HW'(commit_pulse), HW'(0));
    end else begin
      check_eq("load_err", HW'(load_err), HW'(1));
      check_eq("err_commit", HW'(commit_pulse), HW'(0));
      check_eq("err_busy", HW'(busy), HW'(0));
      check_eq("err_ready", HW'(lif.coef_ready), HW'(0));
      check_common("err");
      step();
      check_eq("load_err_end", HW'(load_err), HW'(0));
      check_common("err_after");
    end
  endtask

  task automatic rand_stim();
    for (int k = 0; k < NT; k++) stim[k] = DW'($urandom);
  endtask

  initial begin
    en_force = 1'b1;
    idle_inputs();
    model_clear();
    reset = 1'b1;
    step();
    step();
    check_eq("rst_h_out", h_out, '0);
    check_eq("rst_fir_enable", HW'(fir_enable), HW'(0));
    check_eq("rst_ready", HW'(lif.coef_ready), HW'(0));
    check_eq("rst_busy", HW'(busy), HW'(0));
    check_eq("rst_bank_valid", HW'(bank_valid), HW'(0));
    reset = 1'b0;
    step();

    // Sequential words 1..8, no gaps.
    for (int k = 0; k < NT; k++) stim[k] = DW'(k + 1);
    send_set(NT, 1'b1, 1'b0, 1'b0);
    check_eq("seq_fir_enable", HW'(fir_enable), HW'(1));

    // Short set of 5 and long set without last.
    rand_stim();
    send_set(5, 1'b1, 1'b0, 1'b0);
    rand_stim();
    send_set(NT, 1'b0, 1'b0, 1'b0);

    // Gaps with a re-pulsed load_start mid-load.
    for (int k = 0; k < NT; k++) stim[k] = DW'(k + 1);
    m_active[0] = 16'hDEAD;
    for (int k = 0; k < NT; k++) m_active[k] = DW'(k + 1);
    send_set(NT, 1'b1, 1'b1, 1'b1);

    // Signed extremes on the edge taps.
    rand_stim();
    stim[0]      = 16'h8000;
    stim[NT - 1] = 16'h7FFF;
    send_set(NT, 1'b1, 1'b0, 1'b0);

    // Words offered while idle are ignored.
    en_force = 1'b0;
    for (int c = 0; c < 3; c++) begin
      lif.coef_valid = 1'b1;
      lif.coef_last  = 1'b1;
      lif.coef_data  = DW'($urandom);
      step();
      check_eq("idle_err", HW'(load_err), HW'(0));
      check_eq("idle_busy", HW'(busy), HW'(0));
      check_common("idle");
    end
    idle_inputs();

    // Randomized sets of all three kinds.
    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      rand_stim();
      case (kind)
        0, 1: send_set(NT, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2:    send_set(int'($urandom_range(1, NT - 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        default: send_set(NT, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
      for (int c = int'($urandom_range(0, 2)); c > 0; c--) step();
    end

    // Reset after 4 words of a load over a committed bank.
    rand_stim();
    send_set(NT, 1'b1, 1'b0, 1'b0);
    rand_stim();
    lif.load_start = 1'b1;
    step();
    lif.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lif.coef_valid = 1'b1;
      lif.coef_data  = stim[i];
      step();
    end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check_eq("abort_commit", HW'(commit_pulse), HW'(0));
    check_eq("abort_err", HW'(load_err), HW'(0));
    check_eq("abort_busy", HW'(busy), HW'(0));
    check_common("abort");
    step();
    check_eq("abort2_commit", HW'(commit_pulse), HW'(0));
    check_eq("abort2_err", HW'(load_err), HW'(0));
    check_common("abort2");

    // Loader usable again after the abort.
    rand_stim();
    send_set(NT, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
